// File: rtl/tick_counter_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_counter_ctrl_if : control/status bundle of the slow-tick counter
// Revision 1.0
// ---------------------------------------------------------------------------
interface tick_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             slow_in;
  logic             en;
  logic             up_dn;
  logic             one_shot;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             tick;
  logic             running;
  logic             done;
  logic [6:0]       seg;

  modport master (
    output slow_in, en, up_dn, one_shot, load, load_val,
    input  count, tc, tick, running, done, seg
  );

  modport slave (
    input  slow_in, en, up_dn, one_shot, load, load_val,
    output count, tc, tick, running, done, seg
  );
endinterface
`default_nettype wire

// File: rtl/tick_counter_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_counter_ctrl : edge-detected slow tick driving a mod-(MAX+1) up/down
// counter with load, run/stop, one-shot and 7-segment output. Revision 1.0
// ---------------------------------------------------------------------------
module tick_counter_ctrl #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic                clk,
  input  logic                reset,
  tick_counter_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_slow_d;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nx;
  logic             r_tc;
  logic             w_tc_nx;
  logic             w_tick;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg;

  assign w_tick = bus.slow_in & ~r_slow_d;

  // slow_d resets high so a level already high at release is not a tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slow_d <= 1'b1;
      r_count  <= C_ZERO;
      r_tc     <= 1'b0;
      r_state  <= ST_STOP;
    end else begin
      r_slow_d <= bus.slow_in;
      r_count  <= w_count_nx;
      r_tc     <= w_tc_nx;
      r_state  <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_tc_nx    = 1'b0;
    if (bus.load) begin
      w_count_nx = (bus.load_val > C_MAX) ? C_MAX : bus.load_val;
      if (r_state != ST_STOP && r_state != ST_RUN) begin
        w_state_nx = ST_STOP;
      end
    end else begin
      case (r_state)
        ST_STOP: begin
          if (bus.en) w_state_nx = ST_RUN;
        end
        ST_RUN: begin
          if (!bus.en) begin
            w_state_nx = ST_STOP;
          end else if (w_tick) begin
            if (bus.up_dn) begin
              // anything at or above MAX counts as the up terminal
              if (r_count >= C_MAX) begin
                w_tc_nx = 1'b1;
                if (bus.one_shot) begin
                  w_count_nx = C_MAX;
                  w_state_nx = ST_DONE;
                end else begin
                  w_count_nx = C_ZERO;
                end
              end else begin
                w_count_nx = r_count + C_ONE;
              end
            end else begin
              if (r_count == C_ZERO) begin
                w_tc_nx = 1'b1;
                if (bus.one_shot) begin
                  w_state_nx = ST_DONE;
                end else begin
                  w_count_nx = C_MAX;
                end
              end else begin
                w_count_nx = r_count - C_ONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (!bus.en) w_state_nx = ST_STOP;
        end
        default: w_state_nx = ST_STOP;
      endcase
    end
  end

  generate
    if (WIDTH >= 4) begin : g_nib_wide
      assign w_nib = r_count[3:0];
    end else begin : g_nib_narrow
      assign w_nib = {{(4-WIDTH){1'b0}}, r_count};
    end
  endgenerate

  always_comb begin
    w_seg = 7'b1111111;
    case (w_nib)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      4'hF: w_seg = 7'b0001110;
      default: w_seg = 7'b1111111;
    endcase
  end

  assign bus.count   = r_count;
  assign bus.tc      = r_tc;
  assign bus.tick    = w_tick;
  assign bus.running = (r_state == ST_RUN);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.seg     = w_seg;
endmodule
`default_nettype wire
